// File: rtl/mips_exc_ctrl.sv
// Exception / ERET sequencer for a MIPS-style pipeline: records EPC and Cause in
// CP0 on an exception, then redirects fetch to the handler or back to EPC.
module mips_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_adel,
  input  logic        exc_ades,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic        cop_rd_int,
  input  logic [31:0] cop_rd_epc,
  output logic        cop_wr_en,
  output logic [4:0]  cop_wr_addr,
  output logic [31:0] cop_wr_data,
  output logic        cop_exl_set,
  output logic        cop_exl_reset,
  output logic        cop_cause_en,
  output logic        cop_cause_bd,
  output logic [5:0]  cop_cause_int,
  output logic [3:0]  cop_cause_excode,
  output logic        cop_badvaddr_en,
  output logic [31:0] cop_badvaddr_data,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXC_VEC, ERET_VEC} state_t;

  localparam logic [4:0] EPC_ADDR = 5'd14;

  state_t      state_reg, state_next;
  logic [31:0] epc;
  logic        any_flag;
  logic        take;
  logic [3:0]  excode;
  logic        sel_badvaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cop_cause_int <= 6'd0;
    end else begin
      state_reg     <= state_next;
      cop_cause_int <= hw_int;
    end
  end

  assign epc      = exc_bd ? (exc_pc - 32'd4) : exc_pc;
  assign any_flag = exc_adel | exc_ades | exc_ri | exc_ov | exc_sys | exc_bp;
  assign take     = (state_reg == IDLE) & exc_valid & (cop_rd_int | any_flag);

  // Fixed priority: interrupt first, AdES last; only the winner is reported.
  always_comb begin
    excode       = 4'd0;
    sel_badvaddr = 1'b0;
    if (cop_rd_int) begin
      excode = 4'd0;
    end else if (exc_adel) begin
      excode       = 4'd4;
      sel_badvaddr = 1'b1;
    end else if (exc_ri) begin
      excode = 4'd10;
    end else if (exc_ov) begin
      excode = 4'd12;
    end else if (exc_sys) begin
      excode = 4'd8;
    end else if (exc_bp) begin
      excode = 4'd9;
    end else if (exc_ades) begin
      excode       = 4'd5;
      sel_badvaddr = 1'b1;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cop_wr_en         = 1'b0;
    cop_wr_addr       = 5'd0;
    cop_wr_data       = 32'd0;
    cop_exl_set       = 1'b0;
    cop_exl_reset     = 1'b0;
    cop_cause_en      = 1'b0;
    cop_cause_bd      = 1'b0;
    cop_cause_excode  = 4'd0;
    cop_badvaddr_en   = 1'b0;
    cop_badvaddr_data = 32'd0;
    flush             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 32'd0;
    busy              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (take) begin
          cop_wr_en        = 1'b1;
          cop_wr_addr      = EPC_ADDR;
          cop_wr_data      = epc;
          cop_cause_en     = 1'b1;
          cop_cause_bd     = exc_bd;
          cop_cause_excode = excode;
          cop_exl_set      = 1'b1;
          flush            = 1'b1;
          if (sel_badvaddr) begin
            cop_badvaddr_en   = 1'b1;
            cop_badvaddr_data = exc_badvaddr;
          end
          state_next = EXC_VEC;
        end else if (eret) begin
          cop_exl_reset = 1'b1;
          flush         = 1'b1;
          state_next    = ERET_VEC;
        end else begin
          cop_wr_en   = mtc0_en;
          cop_wr_addr = mtc0_addr;
          cop_wr_data = mtc0_data;
        end
      end
      EXC_VEC: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
        flush       = 1'b1;
        busy        = 1'b1;
        state_next  = IDLE;
      end
      ERET_VEC: begin
        redirect    = 1'b1;
        redirect_pc = cop_rd_epc;
        flush       = 1'b1;
        busy        = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset silences every command in the cycle it is asserted, aborting any redirect.
    if (rst) begin
      state_next        = IDLE;
      cop_wr_en         = 1'b0;
      cop_wr_addr       = 5'd0;
      cop_wr_data       = 32'd0;
      cop_exl_set       = 1'b0;
      cop_exl_reset     = 1'b0;
      cop_cause_en      = 1'b0;
      cop_cause_bd      = 1'b0;
      cop_cause_excode  = 4'd0;
      cop_badvaddr_en   = 1'b0;
      cop_badvaddr_data = 32'd0;
      flush             = 1'b0;
      redirect          = 1'b0;
      redirect_pc       = 32'd0;
      busy              = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_exc_ctrl.sv
// Directed bench for mips_exc_ctrl: exception priority, EPC/BadVAddr capture,
// ERET, MTC0 pass-through, arbitration, reset abort and interrupt sampling.
module tb_mips_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        exc_valid, exc_bd;
  logic [31:0] exc_pc, exc_badvaddr;
  logic        exc_adel, exc_ades, exc_ri, exc_ov, exc_sys, exc_bp;
  logic        eret, mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        cop_rd_int;
  logic [31:0] cop_rd_epc;
  logic        cop_wr_en, cop_exl_set, cop_exl_reset, cop_cause_en, cop_cause_bd;
  logic [4:0]  cop_wr_addr;
  logic [31:0] cop_wr_data, cop_badvaddr_data, redirect_pc;
  logic [5:0]  cop_cause_int;
  logic [3:0]  cop_cause_excode;
  logic        cop_badvaddr_en, flush, redirect, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mips_exc_ctrl #(.EXC_VECTOR(32'h8000_0180)) dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_ri(exc_ri),
    .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp),
    .exc_badvaddr(exc_badvaddr), .eret(eret),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .cop_rd_int(cop_rd_int), .cop_rd_epc(cop_rd_epc),
    .cop_wr_en(cop_wr_en), .cop_wr_addr(cop_wr_addr), .cop_wr_data(cop_wr_data),
    .cop_exl_set(cop_exl_set), .cop_exl_reset(cop_exl_reset),
    .cop_cause_en(cop_cause_en), .cop_cause_bd(cop_cause_bd),
    .cop_cause_int(cop_cause_int), .cop_cause_excode(cop_cause_excode),
    .cop_badvaddr_en(cop_badvaddr_en), .cop_badvaddr_data(cop_badvaddr_data),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-22s got=0x%08h exp=0x%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_bd = 0; exc_pc = 0; exc_badvaddr = 0;
    exc_adel = 0; exc_ades = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
    eret = 0; mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0; cop_rd_int = 0;
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags = {adel, ades, ri, ov, sys, bp}
  task automatic take_case(input string tag, input logic [5:0] flags, input logic irq,
                           input logic [3:0] code, input logic bv);
    clear_inputs();
    exc_valid = 1; exc_pc = 32'h0000_2000; exc_badvaddr = 32'hDEAD_0000;
    {exc_adel, exc_ades, exc_ri, exc_ov, exc_sys, exc_bp} = flags;
    cop_rd_int = irq;
    #1;
    check({tag, "_code"}, {28'd0, cop_cause_excode}, {28'd0, code});
    check({tag, "_bv_en"}, {31'd0, cop_badvaddr_en}, {31'd0, bv});
    check({tag, "_bv_data"}, cop_badvaddr_data, bv ? 32'hDEAD_0000 : 32'd0);
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1; hw_int = 6'h15; cop_rd_epc = 32'h0000_1000;
    tick();
    // Reset held with a pending exception: nothing may leave the block.
    exc_valid = 1; exc_ov = 1;
    #1;
    check("rst_wr_en", {31'd0, cop_wr_en}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_cause_int", {26'd0, cop_cause_int}, 32'd0);
    tick();
    rst = 0; hw_int = 0; clear_inputs();
    tick();

    // Overflow at PC 0x400, not in delay slot.
    exc_valid = 1; exc_ov = 1; exc_pc = 32'h400;
    #1;
    check("ov_wr_en", {31'd0, cop_wr_en}, 32'd1);
    check("ov_wr_addr", {27'd0, cop_wr_addr}, 32'd14);
    check("ov_wr_data", cop_wr_data, 32'h400);
    check("ov_excode", {28'd0, cop_cause_excode}, 32'd12);
    check("ov_cause_en", {31'd0, cop_cause_en}, 32'd1);
    check("ov_exl_set", {31'd0, cop_exl_set}, 32'd1);
    check("ov_flush", {31'd0, flush}, 32'd1);
    check("ov_bv_en", {31'd0, cop_badvaddr_en}, 32'd0);
    check("ov_redirect_n", {31'd0, redirect}, 32'd0);
    tick();
    // EXC_VEC: new exception, eret and mtc0 must all be ignored.
    clear_inputs();
    exc_valid = 1; exc_sys = 1; eret = 1;
    mtc0_en = 1; mtc0_addr = 12; mtc0_data = 32'h401;
    #1;
    check("vec_redirect", {31'd0, redirect}, 32'd1);
    check("vec_pc", redirect_pc, 32'h8000_0180);
    check("vec_busy", {31'd0, busy}, 32'd1);
    check("vec_flush", {31'd0, flush}, 32'd1);
    check("vec_wr_en", {31'd0, cop_wr_en}, 32'd0);
    check("vec_cause_en", {31'd0, cop_cause_en}, 32'd0);
    check("vec_exl_reset", {31'd0, cop_exl_reset}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("back_idle_busy", {31'd0, busy}, 32'd0);
    check("back_idle_redir", {31'd0, redirect}, 32'd0);

    // Delay-slot AdEL with lower-priority RI.
    exc_valid = 1; exc_bd = 1; exc_pc = 32'h404; exc_adel = 1; exc_ri = 1;
    exc_badvaddr = 32'h123;
    #1;
    check("adel_epc", cop_wr_data, 32'h400);
    check("adel_excode", {28'd0, cop_cause_excode}, 32'd4);
    check("adel_bd", {31'd0, cop_cause_bd}, 32'd1);
    check("adel_bv_en", {31'd0, cop_badvaddr_en}, 32'd1);
    check("adel_bv_data", cop_badvaddr_data, 32'h123);
    tick(); clear_inputs(); tick();

    // Delay slot at PC 0 wraps EPC.
    exc_valid = 1; exc_bd = 1; exc_pc = 32'h0; exc_bp = 1;
    #1;
    check("wrap_epc", cop_wr_data, 32'hFFFF_FFFC);
    tick(); clear_inputs(); tick();

    take_case("ades", 6'b010000, 1'b0, 4'd5, 1'b1);
    take_case("ri_ov", 6'b001100, 1'b0, 4'd10, 1'b0);
    take_case("ov_sys", 6'b000110, 1'b0, 4'd12, 1'b0);
    take_case("sys_bp", 6'b000011, 1'b0, 4'd8, 1'b0);
    take_case("bp_ades", 6'b010001, 1'b0, 4'd9, 1'b0);
    take_case("int_sys", 6'b000010, 1'b1, 4'd0, 1'b0);
    take_case("int_adel", 6'b100000, 1'b1, 4'd0, 1'b0);

    // Interrupt pending with no instruction at commit: no take.
    clear_inputs();
    cop_rd_int = 1;
    #1;
    check("int_novalid_wr", {31'd0, cop_wr_en}, 32'd0);
    check("int_novalid_flush", {31'd0, flush}, 32'd0);
    check("int_novalid_cause", {31'd0, cop_cause_en}, 32'd0);
    tick();

    // ERET with simultaneous MTC0: mtc0 dropped.
    clear_inputs();
    eret = 1; mtc0_en = 1; mtc0_addr = 12; mtc0_data = 32'h55;
    #1;
    check("eret_exl_reset", {31'd0, cop_exl_reset}, 32'd1);
    check("eret_flush", {31'd0, flush}, 32'd1);
    check("eret_mtc0_drop", {31'd0, cop_wr_en}, 32'd0);
    check("eret_no_exl_set", {31'd0, cop_exl_set}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("eret_redirect", {31'd0, redirect}, 32'd1);
    check("eret_pc", redirect_pc, 32'h1000);
    check("eret_busy", {31'd0, busy}, 32'd1);
    tick();

    // Take wins over simultaneous eret and mtc0.
    exc_valid = 1; exc_ov = 1; exc_pc = 32'h88; eret = 1;
    mtc0_en = 1; mtc0_addr = 12; mtc0_data = 32'h77;
    #1;
    check("tk_eret_exl_rst", {31'd0, cop_exl_reset}, 32'd0);
    check("tk_eret_addr", {27'd0, cop_wr_addr}, 32'd14);
    check("tk_eret_data", cop_wr_data, 32'h88);
    tick();
    clear_inputs();
    #1;
    check("tk_eret_vec_pc", redirect_pc, 32'h8000_0180);
    tick();

    // MTC0 pass-through in IDLE.
    mtc0_en = 1; mtc0_addr = 12; mtc0_data = 32'h401;
    #1;
    check("mtc0_wr_en", {31'd0, cop_wr_en}, 32'd1);
    check("mtc0_addr", {27'd0, cop_wr_addr}, 32'd12);
    check("mtc0_data", cop_wr_data, 32'h401);
    check("mtc0_flush", {31'd0, flush}, 32'd0);
    tick();
    clear_inputs();

    // Reset during EXC_VEC aborts the redirect.
    exc_valid = 1; exc_sys = 1;
    tick();
    clear_inputs();
    rst = 1;
    #1;
    check("rstvec_redirect", {31'd0, redirect}, 32'd0);
    check("rstvec_pc", redirect_pc, 32'd0);
    tick();
    rst = 0;
    #1;
    check("rstvec_next_redir", {31'd0, redirect}, 32'd0);
    check("rstvec_next_busy", {31'd0, busy}, 32'd0);
    // Back in IDLE: mtc0 is accepted again.
    mtc0_en = 1; mtc0_addr = 5'd9; mtc0_data = 32'h9;
    #1;
    check("rstvec_idle_mtc0", {31'd0, cop_wr_en}, 32'd1);
    tick();
    clear_inputs();

    // Reset during ERET_VEC as well.
    eret = 1;
    tick();
    clear_inputs();
    rst = 1;
    #1;
    check("rsteret_redirect", {31'd0, redirect}, 32'd0);
    tick();
    rst = 0;
    #1;
    check("rsteret_next_redir", {31'd0, redirect}, 32'd0);

    // Interrupt lines register with one cycle of latency.
    hw_int = 6'h3F;
    #1;
    check("hwint_before", {26'd0, cop_cause_int}, 32'd0);
    tick();
    check("hwint_after", {26'd0, cop_cause_int}, 32'h3F);
    hw_int = 6'h0A;
    tick();
    check("hwint_change", {26'd0, cop_cause_int}, 32'h0A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_exc_ctrl.md
MIPS_EXC_CTRL -- requirements
Module: mips_exc_ctrl

Interface
REQ-001 SHALL have parameter: EXC_VECTOR, 32'h8000_0180, exception handler entry address.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port: hw_int  in  6  external interrupt lines.
REQ-005 SHALL have port: exc_valid  in  1  commit-stage instruction present.
REQ-006 SHALL have ports: exc_pc  in  32  commit PC; exc_bd  in  1  instruction sits in a branch delay slot.
REQ-007 SHALL have ports, each in 1, exception flags: exc_adel, exc_ades, exc_ri, exc_ov, exc_sys, exc_bp.
REQ-008 SHALL have port: exc_badvaddr  in  32  faulting address.
REQ-009 SHALL have port: eret  in  1  ERET commits.
REQ-010 SHALL have ports: mtc0_en  in  1, mtc0_addr  in  5, mtc0_data  in  32  pipeline MTC0 request.
REQ-011 SHALL have ports: cop_rd_int  in  1, cop_rd_epc  in  32  from CP0.
REQ-012 SHALL have ports to CP0: cop_wr_en out 1, cop_wr_addr out 5, cop_wr_data out 32, cop_exl_set out 1, cop_exl_reset out 1.
REQ-013 SHALL have ports to CP0: cop_cause_en out 1, cop_cause_bd out 1, cop_cause_int out 6, cop_cause_excode out 4, cop_badvaddr_en out 1, cop_badvaddr_data out 32.
REQ-014 SHALL have ports to pipeline: flush out 1, redirect out 1, redirect_pc out 32, busy out 1.

Function
REQ-015 SHALL implement states IDLE, EXC_VEC, ERET_VEC.
REQ-016 SHALL define take = IDLE & exc_valid & (cop_rd_int | any exc flag).
REQ-017 SHALL select cause by priority: Int(0) > AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdES(5); lower-priority flags are ignored.
REQ-018 On take (cycle N), SHALL drive cop_wr_en=1, cop_wr_addr=14, cop_wr_data=EPC, cop_cause_en=1, cop_cause_bd=exc_bd, cop_cause_excode=selected code, cop_exl_set=1, flush=1, then go to EXC_VEC.
REQ-019 SHALL compute EPC = exc_bd ? exc_pc-32'd4 : exc_pc (mod 2^32).
REQ-020 On take with AdEL or AdES as the selected cause, SHALL also drive cop_badvaddr_en=1 and cop_badvaddr_data=exc_badvaddr; otherwise cop_badvaddr_en=0.
REQ-021 In EXC_VEC (cycle N+1), SHALL drive redirect=1, redirect_pc=EXC_VECTOR, flush=1, busy=1, then go to IDLE.
REQ-022 In IDLE with eret=1 and no take, SHALL drive cop_exl_reset=1, flush=1, then go to ERET_VEC.
REQ-023 In ERET_VEC, SHALL drive redirect=1, redirect_pc=cop_rd_epc, flush=1, busy=1, then go to IDLE.
REQ-024 In IDLE with no take and no eret, SHALL pass mtc0_en/addr/data to cop_wr_en/addr/data unchanged.
REQ-025 On simultaneous take and eret or mtc0, SHALL perform take and drop eret/mtc0; on simultaneous eret and mtc0, SHALL perform eret and drop mtc0.
REQ-026 While busy=1, SHALL ignore exc_valid, eret and mtc0_en.
REQ-027 SHALL register hw_int into cop_cause_int every cycle (1-cycle latency).
REQ-028 When an output is not driven by the rules above, SHALL hold it at 0.

Reset
REQ-029 With rst=1, SHALL set state to IDLE and cop_cause_int to 0, and force every pulse output and redirect_pc to 0 in that cycle.
REQ-030 On rst during EXC_VEC or ERET_VEC, SHALL abort the sequence with no redirect issued.

Verification
REQ-031 SHALL cover: exc_valid=1, exc_ov=1, exc_pc=0x400, exc_bd=0 -> cycle N: wr addr 14, data 0x400, excode 12, exl_set; N+1: redirect to 0x80000180.
REQ-032 SHALL cover: exc_bd=1, exc_pc=0x404, exc_adel=1, exc_ri=1, badvaddr=0x123 -> EPC 0x400, excode 4, cause_bd=1, badvaddr_en with 0x123.
REQ-033 SHALL cover: cop_rd_int=1 plus exc_sys=1 -> excode 0; cop_rd_int=1 with exc_valid=0 -> no take.
REQ-034 SHALL cover: eret=1, cop_rd_epc=0x1000 -> exl_reset at N; redirect 0x1000 at N+1; simultaneous mtc0 dropped.
REQ-035 SHALL cover: mtc0_en=1, addr 12, data 0x401 in IDLE -> identical cop_wr_* the same cycle; mtc0 in EXC_VEC -> no write.
REQ-036 SHALL cover: rst asserted in EXC_VEC -> redirect=0 the next cycle; state IDLE; hw_int=6'h3F -> cop_cause_int=6'h3F one cycle later.
